// File: rtl/dctq_pkg.sv
// Shared widths, limits, types and the 12-bit saturation helper for the dequantiser.
package dctq_pkg;
  localparam int QW   = 9;
  localparam int SW   = 8;
  localparam int CW   = 12;
  localparam int NBLK = 64;
  localparam int IDXW = 6;
  localparam int PW   = QW + SW;

  localparam logic signed [CW-1:0] CMAX = 12'sh7FF;
  localparam logic signed [CW-1:0] CMIN = 12'sh800;
  localparam logic signed [PW-1:0] PMAX = 17'sd2047;
  localparam logic signed [PW-1:0] PMIN = -17'sd2048;

  typedef logic signed [QW-1:0]   dctq_t;
  typedef logic        [SW-1:0]   step_t;
  typedef logic signed [CW-1:0]   coef_t;
  typedef logic        [IDXW-1:0] idx_t;
  typedef logic signed [PW-1:0]   prod_t;

  function automatic coef_t sat_coef(input prod_t p);
    if (p > PMAX)      return CMAX;
    else if (p < PMIN) return CMIN;
    else               return coef_t'(p[CW-1:0]);
  endfunction
endpackage

// File: rtl/dctq_sat_mult.sv
// Combinational 9s x 8u multiply with saturation of the product to 12s.
module dctq_sat_mult
  import dctq_pkg::*;
(
  input  logic [QW-1:0] i_dctq,
  input  logic [SW-1:0] i_step,
  output logic [CW-1:0] o_coef
);
  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_prod;

  // The step is zero-extended so it stays non-negative in the signed multiply.
  assign w_a    = {{SW{i_dctq[QW-1]}}, i_dctq};
  assign w_b    = {{QW{1'b0}}, i_step};
  assign w_prod = w_a * w_b;
  assign o_coef = sat_coef(w_prod);
endmodule

// File: rtl/dctq_dequant.sv
// Dequantiser: 64-entry quant step table, block index counter, 2-stage valid/ready pipe.
module dctq_dequant
  import dctq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            tbl_we,
  input  logic [IDXW-1:0] tbl_addr,
  input  logic [SW-1:0]   tbl_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sob,
  input  logic [QW-1:0]   in_dctq,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_coef,
  output logic [IDXW-1:0] out_idx,
  output logic            out_eob
);
  logic [SW-1:0]   r_tbl [NBLK];
  logic [IDXW-1:0] r_cnt;
  logic            r_s1_valid;
  logic [CW-1:0]   r_s1_coef;
  logic [IDXW-1:0] r_s1_idx;
  logic            r_s2_valid;
  logic [CW-1:0]   r_s2_coef;
  logic [IDXW-1:0] r_s2_idx;
  logic            r_s2_eob;

  logic            w_adv;
  logic            w_acc;
  logic [IDXW-1:0] w_idx;
  logic [SW-1:0]   w_step;
  logic [CW-1:0]   w_coef;

  assign w_adv  = !r_s2_valid || out_ready;
  assign w_acc  = in_valid && w_adv;
  assign w_idx  = in_sob ? '0 : r_cnt;
  assign w_step = r_tbl[w_idx];

  // Saturation sits ahead of the S1 register; the output sequence is the same
  // as saturating in S2, and S1 only carries 12 bits.
  dctq_sat_mult u_sat_mult (
    .i_dctq (in_dctq),
    .i_step (w_step),
    .o_coef (w_coef)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBLK; i++) r_tbl[i] <= SW'(1);
    end else if (tbl_we) begin
      r_tbl[tbl_addr] <= tbl_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= w_idx + IDXW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_coef  <= '0;
      r_s1_idx   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_coef  <= '0;
      r_s2_idx   <= '0;
      r_s2_eob   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= w_acc;
      r_s2_valid <= r_s1_valid;
      if (w_acc) begin
        r_s1_coef <= w_coef;
        r_s1_idx  <= w_idx;
      end
      if (r_s1_valid) begin
        r_s2_coef <= r_s1_coef;
        r_s2_idx  <= r_s1_idx;
        r_s2_eob  <= (r_s1_idx == IDXW'(NBLK - 1));
      end
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_s2_valid;
  assign out_coef  = r_s2_coef;
  assign out_idx   = r_s2_idx;
  assign out_eob   = r_s2_eob;
endmodule

// File: tb/tb_dctq_dequant.sv
// Randomised bench for dctq_dequant against a queue-based arithmetic reference model.
module tb_dctq_dequant;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tbl_we = 1'b0;
  logic [5:0] tbl_addr = '0;
  logic [7:0] tbl_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sob = 1'b0;
  logic [8:0] in_dctq = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [11:0] out_coef;
  logic [5:0] out_idx;
  logic       out_eob;

  dctq_dequant dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_sob(in_sob), .in_dctq(in_dctq),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_idx(out_idx), .out_eob(out_eob)
  );

  always #5 clk = ~clk;

  typedef struct { int coef; int idx; int eob; int acyc; } exp_t;
  exp_t q[$];
  int   m_tbl [64];
  int   m_cnt = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   lat_en = 1'b0;
  bit   rdy_mode = 1'b0;
  bit   hold_v = 1'b0;
  int   h_coef, h_idx, h_eob;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode) out_ready = 1'($urandom_range(0, 1));
    else          out_ready = 1'b1;
  end

  // Reference: everything below works on plain integers and a FIFO of expected beats.
  always @(negedge clk) begin
    int idx, p;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      for (int i = 0; i < 64; i++) m_tbl[i] = 1;
      m_cnt  = 0;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_coef", int'($signed(out_coef)), h_coef);
        chk("stall_idx", int'(out_idx), h_idx);
        chk("stall_eob", int'(out_eob), h_eob);
      end
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_beat_queue_depth", q.size(), 1);
        else begin
          e = q[0];
          chk("coef", int'($signed(out_coef)), e.coef);
          chk("idx", int'(out_idx), e.idx);
          chk("eob", int'(out_eob), e.eob);
          if (lat_en && !hold_v) chk("latency", cyc - e.acyc, 2);
          if (out_ready) void'(q.pop_front());
        end
      end
      hold_v = out_valid && !out_ready;
      h_coef = int'($signed(out_coef));
      h_idx  = int'(out_idx);
      h_eob  = int'(out_eob);
      if (in_valid && in_ready) begin
        idx = in_sob ? 0 : m_cnt;
        p = int'($signed(in_dctq)) * m_tbl[idx];
        if (p > 2047) p = 2047;
        if (p < -2048) p = -2048;
        e.coef = p; e.idx = idx; e.eob = (idx == 63) ? 1 : 0; e.acyc = cyc;
        q.push_back(e);
        m_cnt = (idx + 1) % 64;
      end
      if (tbl_we) m_tbl[tbl_addr] = int'(tbl_data);
    end
  end

  task automatic step_cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input int dq, input bit sob, input bit we = 1'b0,
                      input int wa = 0, input int wd = 0);
    int  n = 0;
    bit  done = 1'b0;
    in_valid = 1'b1; in_dctq = dq[8:0]; in_sob = sob;
    tbl_we = we; tbl_addr = wa[5:0]; tbl_data = wd[7:0];
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      step_cyc();
      n++;
      if (!done && n > 1000) begin
        chk("push_timeout_in_ready", int'(in_ready), 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0; in_sob = 1'b0; tbl_we = 1'b0;
  endtask

  task automatic tbl_write(input int a, input int d);
    tbl_we = 1'b1; tbl_addr = a[5:0]; tbl_data = d[7:0];
    step_cyc();
    tbl_we = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin
      step_cyc();
      n++;
    end
    if (q.size() != 0) chk("drain_timeout_queue_depth", q.size(), 0);
    step_cyc();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_coef"}, int'(out_coef), 0);
    chk({tag, "_out_idx"}, int'(out_idx), 0);
    chk({tag, "_out_eob"}, int'(out_eob), 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    step_cyc();
    lat_en = 1'b1;

    // identity table, back-to-back beats
    push(5, 1'b1);
    push(-5, 1'b0);
    drain(50);

    // step 128 and step 0
    tbl_write(0, 128);
    push(-1, 1'b1);
    drain(50);
    tbl_write(0, 0);
    push(100, 1'b1);
    drain(50);

    // saturation at both ends
    tbl_write(0, 255);
    push(255, 1'b1);
    push(-256, 1'b1);
    push(0, 1'b1);
    drain(50);

    // full block plus one, then sob mid-block
    tbl_write(0, 1);
    for (int i = 0; i < 65; i++) push(i * 3 - 90, i == 0);
    drain(50);
    for (int i = 0; i < 20; i++) push(i - 7, i == 0 || i == 10);
    drain(50);
    lat_en = 1'b0;

    // random backpressure, gaps and table writes over three blocks
    rdy_mode = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 3) == 0) step_cyc();
        if ($urandom_range(0, 7) == 0)
          tbl_write(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
        if ($urandom_range(0, 9) == 0)
          push(int'($urandom_range(0, 511)) - 256, i == 0, 1'b1,
               int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));
        else
          push(int'($urandom_range(0, 511)) - 256, i == 0);
      end
    end
    drain(2000);
    rdy_mode = 1'b0;
    step_cyc();

    // write to step[3] in the same cycle as the idx-3 read
    tbl_write(3, 1);
    lat_en = 1'b1;
    for (int i = 0; i < 8; i++) push(10 + i, i == 0, i == 3, 3, 5);
    drain(50);
    for (int i = 0; i < 8; i++) push(10 + i, i == 0);
    drain(50);

    // reset with beats in flight
    tbl_write(3, 9);
    for (int i = 0; i < 5; i++) push(20 + i, i == 0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step_cyc();
    for (int i = 0; i < 5; i++) push(7, 1'b0);
    drain(50);
    lat_en = 1'b0;

    chk("final_queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
